// File: rtl/multi_dispatcher_pkg.sv
// Shared parameters, destination codes and field helpers for the result dispatcher.
// Worker result: [63:61] dest option, [60:48] dest addr, [47:32] color, [31:0] data.
package multi_dispatcher_pkg;

    localparam int unsigned WORKER_RESULT_WIDTH  = 64;
    localparam int unsigned PACKET_REQUEST_WIDTH = 96;

    localparam logic [2:0] DEST_OPTION_EXEC  = 3'd0;
    localparam logic [2:0] DEST_OPTION_ONE   = 3'd1;
    localparam logic [2:0] DEST_OPTION_LEFT  = 3'd2;
    localparam logic [2:0] DEST_OPTION_RIGHT = 3'd3;
    localparam logic [2:0] DEST_OPTION_END   = 3'd4;

    typedef enum logic [1:0] {
        ClsPr,
        ClsWr,
        ClsEnd,
        ClsDrop
    } dest_class_e;

    function automatic logic [2:0] wr_dest_option(input logic [WORKER_RESULT_WIDTH-1:0] w);
        return w[63:61];
    endfunction

    function automatic logic [12:0] wr_dest_addr(input logic [WORKER_RESULT_WIDTH-1:0] w);
        return w[60:48];
    endfunction

    function automatic logic [15:0] wr_color(input logic [WORKER_RESULT_WIDTH-1:0] w);
        return w[47:32];
    endfunction

    function automatic logic [31:0] wr_data(input logic [WORKER_RESULT_WIDTH-1:0] w);
        return w[31:0];
    endfunction

    function automatic dest_class_e dest_class(input logic [2:0] opt);
        dest_class_e cls;
        case (opt)
            DEST_OPTION_EXEC, DEST_OPTION_ONE:  cls = ClsPr;
            DEST_OPTION_LEFT, DEST_OPTION_RIGHT: cls = ClsWr;
            DEST_OPTION_END:                    cls = ClsEnd;
            default:                            cls = ClsDrop;
        endcase
        return cls;
    endfunction

    function automatic logic [PACKET_REQUEST_WIDTH-1:0] make_packet_request(
        input logic [2:0]  dest_option,
        input logic [12:0] dest_addr,
        input logic [15:0] color,
        input logic [31:0] data,
        input logic [31:0] extra
    );
        return {dest_option, dest_addr, color, data, extra};
    endfunction

endpackage

// File: rtl/dispatcher_fifo.sv
// Output FIFO for the dispatcher with registered full/empty flags.
// Pushes while full are ignored; the caller gates its push on full_o.
module dispatcher_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
        full_d  = (count_d == CntW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage carries no reset; validity is tracked by the counters alone.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = !empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/multi_dispatcher.sv
// Round-robin worker-result dispatcher routing to packet loader / matching memory FIFOs.
// Optional MULTI_DISPATCHER_STATS_EN adds saturating per-class accept counters.
module multi_dispatcher
    import multi_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_IN     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    output logic                                  EXECUTION_END,
    input  logic [NUM_IN-1:0]                     RECEIVE_WR_VALID,
    input  logic [NUM_IN*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
    output logic [NUM_IN-1:0]                     RECEIVE_WR_READY,
    output logic                                  SEND_WR_VALID,
    output logic [WORKER_RESULT_WIDTH-1:0]        SEND_WR_DATA,
    input  logic                                  SEND_WR_READY,
`ifdef MULTI_DISPATCHER_STATS_EN
    output logic [31:0]                           STAT_PR,
    output logic [31:0]                           STAT_WR,
    output logic [31:0]                           STAT_DROP,
`endif
    output logic                                  SEND_PR_VALID,
    output logic [PACKET_REQUEST_WIDTH-1:0]       SEND_PR_DATA,
    input  logic                                  SEND_PR_READY
);

    localparam int unsigned W    = WORKER_RESULT_WIDTH;
    localparam int unsigned PtrW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StEnd
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;

    logic [W-1:0]    words [NUM_IN];
    dest_class_e     cls   [NUM_IN];
    logic [NUM_IN-1:0] eligible;

    logic            grant_vld;
    logic [PtrW-1:0] grant_idx;
    int              scan_idx;
    logic            accept;
    logic [W-1:0]    win_word;
    dest_class_e     win_cls;

    logic wr_full, pr_full, wr_valid, pr_valid;
    logic push_wr, push_pr;
    logic [PACKET_REQUEST_WIDTH-1:0] pr_word;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            words[i] = RECEIVE_WR_DATA[i*W +: W];
            cls[i]   = dest_class(wr_dest_option(words[i]));
            unique case (cls[i])
                ClsPr:   eligible[i] = RECEIVE_WR_VALID[i] && !pr_full;
                ClsWr:   eligible[i] = RECEIVE_WR_VALID[i] && !wr_full;
                default: eligible[i] = RECEIVE_WR_VALID[i];
            endcase
        end
    end

    // Scan from rr_ptr upward; first eligible channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_IN;
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = PtrW'(scan_idx);
            end
        end
    end

    assign accept   = (state_q == StRun) && grant_vld;
    assign win_word = words[grant_idx];
    assign win_cls  = cls[grant_idx];

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            RECEIVE_WR_READY[i] = accept && (grant_idx == PtrW'(i));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + PtrW'(1);
        end
    end

    assign push_wr = accept && (win_cls == ClsWr);
    assign push_pr = accept && (win_cls == ClsPr);
    assign pr_word = make_packet_request(wr_dest_option(win_word), wr_dest_addr(win_word),
                                         wr_color(win_word), wr_data(win_word), 32'b0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (accept && (win_cls == ClsEnd)) state_d = StDrain;
            StDrain: if (!wr_valid && !pr_valid) state_d = StEnd;
            StEnd:   state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StRun;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign EXECUTION_END = (state_q == StEnd);

    dispatcher_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) wr_fifo (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .push_i      (push_wr),
        .push_data_i (win_word),
        .pop_i       (SEND_WR_READY),
        .head_o      (SEND_WR_DATA),
        .valid_o     (wr_valid),
        .full_o      (wr_full)
    );

    dispatcher_fifo #(
        .WIDTH (PACKET_REQUEST_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) pr_fifo (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .push_i      (push_pr),
        .push_data_i (pr_word),
        .pop_i       (SEND_PR_READY),
        .head_o      (SEND_PR_DATA),
        .valid_o     (pr_valid),
        .full_o      (pr_full)
    );

    assign SEND_WR_VALID = wr_valid;
    assign SEND_PR_VALID = pr_valid;

`ifdef MULTI_DISPATCHER_STATS_EN
    logic [31:0] stat_pr_q, stat_wr_q, stat_drop_q;
    logic        push_drop;

    assign push_drop = accept && (win_cls == ClsDrop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stat_pr_q   <= '0;
            stat_wr_q   <= '0;
            stat_drop_q <= '0;
        end else begin
            if (push_pr && (stat_pr_q != '1))     stat_pr_q   <= stat_pr_q + 32'd1;
            if (push_wr && (stat_wr_q != '1))     stat_wr_q   <= stat_wr_q + 32'd1;
            if (push_drop && (stat_drop_q != '1)) stat_drop_q <= stat_drop_q + 32'd1;
        end
    end

    assign STAT_PR   = stat_pr_q;
    assign STAT_WR   = stat_wr_q;
    assign STAT_DROP = stat_drop_q;
`endif

endmodule

// File: tb/tb_multi_dispatcher.sv
// Scoreboard bench for multi_dispatcher: expected outputs queued on accept, compared on pop.
module tb_multi_dispatcher;
    import multi_dispatcher_pkg::*;

    localparam int NI = 2;
    localparam int FD = 4;
    localparam int W  = WORKER_RESULT_WIDTH;
    localparam int P  = PACKET_REQUEST_WIDTH;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          EXECUTION_END;
    logic [NI-1:0] RECEIVE_WR_VALID;
    logic [NI*W-1:0] RECEIVE_WR_DATA;
    logic [NI-1:0] RECEIVE_WR_READY;
    logic          SEND_WR_VALID, SEND_WR_READY;
    logic [W-1:0]  SEND_WR_DATA;
    logic          SEND_PR_VALID, SEND_PR_READY;
    logic [P-1:0]  SEND_PR_DATA;
`ifdef MULTI_DISPATCHER_STATS_EN
    logic [31:0]   STAT_PR, STAT_WR, STAT_DROP;
`endif

    logic         vld [NI];
    logic [W-1:0] dat [NI];
    logic [W-1:0] stim_q [NI][$];

    assign RECEIVE_WR_VALID = {vld[1], vld[0]};
    assign RECEIVE_WR_DATA  = {dat[1], dat[0]};

    multi_dispatcher #(
        .NUM_IN     (NI),
        .FIFO_DEPTH (FD)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .EXECUTION_END    (EXECUTION_END),
        .RECEIVE_WR_VALID (RECEIVE_WR_VALID),
        .RECEIVE_WR_DATA  (RECEIVE_WR_DATA),
        .RECEIVE_WR_READY (RECEIVE_WR_READY),
        .SEND_WR_VALID    (SEND_WR_VALID),
        .SEND_WR_DATA     (SEND_WR_DATA),
        .SEND_WR_READY    (SEND_WR_READY),
`ifdef MULTI_DISPATCHER_STATS_EN
        .STAT_PR          (STAT_PR),
        .STAT_WR          (STAT_WR),
        .STAT_DROP        (STAT_DROP),
`endif
        .SEND_PR_VALID    (SEND_PR_VALID),
        .SEND_PR_DATA     (SEND_PR_DATA),
        .SEND_PR_READY    (SEND_PR_READY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [2:0] o, input int n);
        return {o, 13'(n * 7), 16'(n ^ 32'hA5A5), 32'(n * 32'h0101_0101 + 1)};
    endfunction

    // Scoreboard state, updated at the falling edge when handshakes are stable.
    logic [W-1:0] wr_exp [$];
    logic [P-1:0] pr_exp [$];
    int grant_q [$];
    int acc_cyc [$];
    int n_acc = 0, n_wr = 0, n_pr = 0, n_end = 0, n_drop = 0;
    int n_wr_pop = 0, n_pr_pop = 0, n_pulse = 0;
    int last_acc = 0, last_wr_pop = 0, pulse_cyc = 0, end_cyc = 0;
    int pr_pop_cyc [$];

    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if ($countones(RECEIVE_WR_READY) > 1) check_eq("ready_onehot", 128'(RECEIVE_WR_READY), 0);
            for (int ch = 0; ch < NI; ch++) begin
                if (vld[ch] && RECEIVE_WR_READY[ch]) begin
                    logic [W-1:0] w;
                    w = dat[ch];
                    n_acc++;
                    last_acc = cyc;
                    acc_cyc.push_back(cyc);
                    grant_q.push_back(ch);
                    case (w[63:61])
                        3'd0, 3'd1: begin
                            pr_exp.push_back({w[63:61], w[60:48], w[47:32], w[31:0], 32'h0});
                            n_pr++;
                        end
                        3'd2, 3'd3: begin
                            wr_exp.push_back(w);
                            n_wr++;
                        end
                        3'd4: begin
                            n_end++;
                            end_cyc = cyc;
                        end
                        default: n_drop++;
                    endcase
                end
            end
            if (SEND_WR_VALID && SEND_WR_READY) begin
                n_wr_pop++;
                last_wr_pop = cyc;
                check_eq("wr_sb_nonempty", 128'(wr_exp.size() != 0), 1);
                if (wr_exp.size() != 0) check_eq("wr_data", 128'(SEND_WR_DATA), 128'(wr_exp.pop_front()));
            end
            if (SEND_PR_VALID && SEND_PR_READY) begin
                n_pr_pop++;
                pr_pop_cyc.push_back(cyc);
                check_eq("pr_sb_nonempty", 128'(pr_exp.size() != 0), 1);
                if (pr_exp.size() != 0) check_eq("pr_data", 128'(SEND_PR_DATA), 128'(pr_exp.pop_front()));
            end
            if (EXECUTION_END) begin
                n_pulse++;
                pulse_cyc = cyc;
            end
        end
    end

    // Per-channel driver: presents the queue head and holds it until accepted.
    task automatic run_driver(input int ch);
        bit will;
        vld[ch] = 1'b0;
        dat[ch] = '0;
        forever begin
            @(negedge CLK);
            will = vld[ch] && RECEIVE_WR_READY[ch] && (RST_N === 1'b1);
            @(posedge CLK);
            #1;
            if (will && stim_q[ch].size() != 0) void'(stim_q[ch].pop_front());
            if (stim_q[ch].size() != 0) begin
                vld[ch] = 1'b1;
                dat[ch] = stim_q[ch][0];
            end else begin
                vld[ch] = 1'b0;
            end
        end
    endtask

    initial run_driver(0);
    initial run_driver(1);

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_var(input string tag, input int which, input int target);
        int b = 0;
        int v;
        v = 0;
        while (b < 200) begin
            case (which)
                0: v = n_acc;
                1: v = n_wr;
                2: v = n_end;
                3: v = n_pulse;
                4: v = n_drop;
                default: v = wr_exp.size() + pr_exp.size();
            endcase
            if ((which == 5) ? (v == target) : (v >= target)) break;
            step();
            b++;
        end
        check_eq(tag, 128'(v), 128'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, gbase, pbase, rc, pb;
        RST_N = 1'b0;
        SEND_WR_READY = 1'b0;
        SEND_PR_READY = 1'b0;
        repeat (3) step();
        RST_N = 1'b1;
        step();

        check_eq("rst_ready", 128'(RECEIVE_WR_READY), 0);
        check_eq("rst_wr_valid", 128'(SEND_WR_VALID), 0);
        check_eq("rst_pr_valid", 128'(SEND_PR_VALID), 0);
        check_eq("rst_exec_end", 128'(EXECUTION_END), 0);

        // Single route: LEFT on ch0 emerges the cycle after accept.
        SEND_WR_READY = 1'b1;
        base = n_acc;
        stim_q[0].push_back(mk(DEST_OPTION_LEFT, 1));
        wait_var("route_acc", 0, base + 1);
        check_eq("route_wr_valid", 128'(SEND_WR_VALID), 1);
        check_eq("route_wr_data", 128'(SEND_WR_DATA), 128'(mk(3'd2, 1)));
        check_eq("route_pr_valid", 128'(SEND_PR_VALID), 0);
        repeat (3) step();

        // Fairness: rr_ptr is 1 after the ch0 accept, so ch1 wins first.
        SEND_PR_READY = 1'b1;
        base  = n_acc;
        gbase = grant_q.size();
        pbase = pr_pop_cyc.size();
        for (int k = 0; k < 6; k++) begin
            stim_q[0].push_back(mk(DEST_OPTION_EXEC, 100 + k));
            stim_q[1].push_back(mk(DEST_OPTION_ONE, 200 + k));
        end
        wait_var("fair_acc", 0, base + 12);
        for (int k = 0; k < 12; k++) check_eq("fair_grant", 128'(grant_q[gbase + k]), 128'((k + 1) % 2));
        for (int k = 1; k < 12; k++) check_eq("fair_rate", 128'(acc_cyc[base + k] - acc_cyc[base + k - 1]), 1);
        repeat (4) step();
        check_eq("fair_pr_pops", 128'(pr_pop_cyc.size() - pbase), 12);
        check_eq("fair_pr_rate", 128'(pr_pop_cyc[pbase + 11] - pr_pop_cyc[pbase]), 11);

        // Backpressure: WR FIFO fills at 4, ch1 PR traffic keeps flowing.
        SEND_WR_READY = 1'b0;
        base  = n_wr;
        pbase = n_pr;
        for (int k = 0; k < 5; k++) stim_q[0].push_back(mk(DEST_OPTION_LEFT, 300 + k));
        for (int k = 0; k < 4; k++) stim_q[1].push_back(mk(DEST_OPTION_EXEC, 400 + k));
        repeat (15) step();
        check_eq("bp_wr_accepted", 128'(n_wr - base), 4);
        check_eq("bp_pr_accepted", 128'(n_pr - pbase), 4);
        check_eq("bp_ready0_low", 128'(RECEIVE_WR_READY[0]), 0);
        check_eq("bp_wr_valid", 128'(SEND_WR_VALID), 1);
        SEND_WR_READY = 1'b1;
        rc = cyc;
        wait_var("bp_fifth_acc", 1, base + 5);
        check_eq("bp_fifth_timing", 128'(last_acc), 128'(rc + 1));
        wait_var("bp_drained", 5, 0);

        // END drain: queued RIGHT words hold off the pulse.
        SEND_WR_READY = 1'b0;
        base = n_wr;
        pb   = n_pulse;
        for (int k = 0; k < 3; k++) stim_q[0].push_back(mk(DEST_OPTION_RIGHT, 500 + k));
        wait_var("drain_wr_acc", 1, base + 3);
        stim_q[1].push_back(mk(DEST_OPTION_END, 600));
        wait_var("drain_end_acc", 2, n_end + 1);
        repeat (5) step();
        check_eq("drain_no_pulse", 128'(n_pulse), 128'(pb));
        stim_q[0].push_back(mk(DEST_OPTION_RIGHT, 700));
        repeat (3) step();
        check_eq("drain_ready_low", 128'(RECEIVE_WR_READY), 0);
        check_eq("drain_no_accept", 128'(n_wr), 128'(base + 3));
        SEND_WR_READY = 1'b1;
        wait_var("drain_pulse", 3, pb + 1);
        check_eq("drain_pulse_timing", 128'(pulse_cyc), 128'(last_wr_pop + 2));
        repeat (4) step();
        check_eq("drain_single_pulse", 128'(n_pulse), 128'(pb + 1));
        check_eq("drain_resume_acc", 128'(n_wr), 128'(base + 4));
        check_eq("drain_resume_timing", 128'(last_acc), 128'(pulse_cyc + 1));
        wait_var("drain_empty", 5, 0);
        repeat (2) step();

        // END with empty FIFOs pulses two cycles after accept.
        pb = n_pulse;
        stim_q[0].push_back(mk(DEST_OPTION_END, 800));
        wait_var("end_fast_pulse", 3, pb + 1);
        check_eq("end_fast_timing", 128'(pulse_cyc), 128'(end_cyc + 2));
        repeat (3) step();

        // Drop: unknown codes are consumed without any output.
        base  = n_wr_pop;
        pbase = n_pr_pop;
        gbase = n_drop;
        stim_q[1].push_back(mk(3'd7, 900));
        stim_q[1].push_back(mk(3'd5, 901));
        wait_var("drop_acc", 4, gbase + 2);
        repeat (3) step();
        check_eq("drop_no_wr", 128'(n_wr_pop), 128'(base));
        check_eq("drop_no_pr", 128'(n_pr_pop), 128'(pbase));
        check_eq("drop_wr_valid", 128'(SEND_WR_VALID), 0);
        check_eq("drop_pr_valid", 128'(SEND_PR_VALID), 0);
`ifdef MULTI_DISPATCHER_STATS_EN
        check_eq("stat_drop", 128'(STAT_DROP), 128'(n_drop));
        check_eq("stat_wr", 128'(STAT_WR), 128'(n_wr));
        check_eq("stat_pr", 128'(STAT_PR), 128'(n_pr));
`endif

        // Reset with two entries queued discards them.
        SEND_WR_READY = 1'b0;
        base = n_wr;
        stim_q[0].push_back(mk(DEST_OPTION_LEFT, 1000));
        stim_q[0].push_back(mk(DEST_OPTION_LEFT, 1001));
        wait_var("rst_fill", 1, base + 2);
        step();
        check_eq("rst_pre_valid", 128'(SEND_WR_VALID), 1);
        RST_N = 1'b0;
        #1;
        check_eq("rst_async_valid", 128'(SEND_WR_VALID), 0);
        wr_exp.delete();
        pr_exp.delete();
        repeat (2) step();
        RST_N = 1'b1;
        SEND_WR_READY = 1'b1;
        base = n_wr_pop;
        repeat (3) step();
        check_eq("rst_post_wr_valid", 128'(SEND_WR_VALID), 0);
        check_eq("rst_post_pr_valid", 128'(SEND_PR_VALID), 0);
        check_eq("rst_post_no_pop", 128'(n_wr_pop), 128'(base));
`ifdef MULTI_DISPATCHER_STATS_EN
        check_eq("rst_stat_wr", 128'(STAT_WR), 0);
`endif
        // rr_ptr back at 0: ch0 wins first when both present together.
        base  = n_acc;
        gbase = grant_q.size();
        stim_q[0].push_back(mk(DEST_OPTION_EXEC, 1100));
        stim_q[1].push_back(mk(DEST_OPTION_EXEC, 1101));
        wait_var("rst_rr_acc", 0, base + 2);
        check_eq("rst_rr_first", 128'(grant_q[gbase]), 0);
        wait_var("final_empty", 5, 0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
